sevseg_scan_driver: RTL and testbench

- Time-multiplexed N-digit driver for common-anode 7-segment displays.
- Latches a packed nibble vector and scans one digit per refresh slot, decoding 0-F (or BCD-only) to active-low segments.
- Drives active-low anodes and decimal points.
- Double-buffers input data so the display changes only at frame boundaries, with no digit tearing.
- Sits between the ALU result path and the board's display pins.

---
 rtl/sevseg_scan_driver.sv | 176 +++++++++++++++++
 tb/tb_sevseg_scan_driver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sevseg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with frame-synchronous double buffering.
// Define SEVSEG_LZB_EN to build in leading-zero blanking.
module sevseg_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int HEX_MODE    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4*N_DIGITS-1:0] i_data,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic                  i_load,
    input  logic                  i_enable,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [N_DIGITS-1:0]   o_an,
    output logic                  o_frame_tick
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] dispData_q, dispData_d, pendData_q, pendData_d;
    logic [N_DIGITS-1:0]   dispDp_q, dispDp_d, pendDp_q, pendDp_d;
    logic                  pendValid_q, pendValid_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  tick_q, tick_d;
    logic                  slotWrap, frameWrap;
    logic [3:0]            selNib;
    logic                  selDp, selBlank;
    logic [N_DIGITS-1:0]   lzBlank;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        if (HEX_MODE == 0 && nib > 4'd9) begin
            s = 7'h7F;
        end
        return s;
    endfunction

    // Scan timing: disabled holds everything at digit 0 so re-enable starts a fresh slot.
    always_comb begin
        slotWrap  = i_enable && (cnt_q == CNT_LAST);
        frameWrap = slotWrap && (idx_q == IDX_LAST);
        if (!i_enable) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (slotWrap) begin
            cnt_d = '0;
            idx_d = frameWrap ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
    end

    // A load landing on the frame wrap bypasses the pending buffer so it shows immediately.
    always_comb begin
        dispData_d  = dispData_q;
        dispDp_d    = dispDp_q;
        pendData_d  = pendData_q;
        pendDp_d    = pendDp_q;
        pendValid_d = pendValid_q;
        if (i_load && frameWrap) begin
            dispData_d  = i_data;
            dispDp_d    = i_dp;
            pendValid_d = 1'b0;
        end else if (i_load) begin
            pendData_d  = i_data;
            pendDp_d    = i_dp;
            pendValid_d = 1'b1;
        end else if (frameWrap && pendValid_q) begin
            dispData_d  = pendData_q;
            dispDp_d    = pendDp_q;
            pendValid_d = 1'b0;
        end
    end

`ifdef SEVSEG_LZB_EN
    logic lzRun;

    always_comb begin
        lzRun   = 1'b1;
        lzBlank = '0;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            lzRun      = lzRun && (dispData_d[4*k +: 4] == 4'd0) && !dispDp_d[k];
            lzBlank[k] = lzRun;
        end
    end
`else
    assign lzBlank = '0;
`endif

    // Pins follow the next-state index so a new slot appears on the same edge it begins.
    always_comb begin
        selNib   = '0;
        selDp    = 1'b0;
        selBlank = 1'b0;
        an_d     = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                selNib   = dispData_d[4*k +: 4];
                selDp    = dispDp_d[k];
                selBlank = lzBlank[k];
            end
        end
        tick_d = frameWrap;
        if (!i_enable) begin
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end else begin
            seg_d = selBlank ? 7'h7F : decode(selNib);
            dp_d  = ~selDp;
            for (int k = 0; k < N_DIGITS; k++) begin
                an_d[k] = (idx_d != IDX_W'(k));
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            dispData_q  <= '0;
            dispDp_q    <= '0;
            pendData_q  <= '0;
            pendDp_q    <= '0;
            pendValid_q <= 1'b0;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            an_q        <= '1;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dispData_q  <= dispData_d;
            dispDp_q    <= dispDp_d;
            pendData_q  <= pendData_d;
            pendDp_q    <= pendDp_d;
            pendValid_q <= pendValid_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            tick_q      <= tick_d;
        end
    end

    assign o_seg        = seg_q;
    assign o_dp         = dp_q;
    assign o_an         = an_q;
    assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Self-checking bench for sevseg_scan_driver: a time-based display model plus directed literal checks.
module tb_sevseg_scan_driver;
    localparam int ND = 4;
    localparam int RD = 4;
`ifdef SEVSEG_LZB_EN
    localparam logic [6:0] HIGH_ZERO = 7'h7F;
`else
    localparam logic [6:0] HIGH_ZERO = 7'h40;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic        load = 1'b0;
    logic        enable = 1'b0;
    logic [6:0]  seg;
    logic        oDp;
    logic [3:0]  an;
    logic        tick;

    logic [15:0] data2 = 16'h9A00;
    logic [3:0]  dp2 = 4'b0000;
    logic [6:0]  seg2;
    logic        oDp2;
    logic [3:0]  an2;
    logic        tick2;

    int nVec = 0;
    int nErr = 0;

    logic [6:0] segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    sevseg_scan_driver #(.N_DIGITS(ND), .REFRESH_DIV(RD), .HEX_MODE(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_dp(dp), .i_load(load),
        .i_enable(enable), .o_seg(seg), .o_dp(oDp), .o_an(an), .o_frame_tick(tick)
    );

    sevseg_scan_driver #(.N_DIGITS(ND), .REFRESH_DIV(RD), .HEX_MODE(0)) dutHex0 (
        .i_clk(clk), .i_rst(rst), .i_data(data2), .i_dp(dp2), .i_load(load),
        .i_enable(enable), .o_seg(seg2), .o_dp(oDp2), .o_an(an2), .o_frame_tick(tick2)
    );

    always #5 clk = ~clk;

    // Model: mT counts enabled edges since scanning restarted; digit and frame follow from it.
    int          mT = 0;
    logic [15:0] mShownData = '0;
    logic [3:0]  mShownDp = '0;
    logic [15:0] mPendData = '0;
    logic [3:0]  mPendDp = '0;
    bit          mPendValid = 0;
    bit          mTick = 0;
    bit          mLit = 0;
    bit          mFrame;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mT = 0; mShownData = '0; mShownDp = '0; mPendData = '0; mPendDp = '0;
            mPendValid = 0; mTick = 0; mLit = 0;
        end else begin
            mT = enable ? mT + 1 : 0;
            mFrame = enable && (mT % (RD * ND) == 0);
            if (load && mFrame) begin
                mShownData = data; mShownDp = dp; mPendValid = 0;
            end else if (load) begin
                mPendData = data; mPendDp = dp; mPendValid = 1;
            end else if (mFrame && mPendValid) begin
                mShownData = mPendData; mShownDp = mPendDp; mPendValid = 0;
            end
            mTick = mFrame;
            mLit = enable;
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name, input logic [6:0] eSeg, input logic [3:0] eAn,
                               input logic eDp, input logic eTick);
        checkVal({name, ".seg"}, 32'(seg), 32'(eSeg));
        checkVal({name, ".an"}, 32'(an), 32'(eAn));
        checkVal({name, ".dp"}, 32'(oDp), 32'(eDp));
        checkVal({name, ".tick"}, 32'(tick), 32'(eTick));
    endtask

    task automatic waitEdge(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every cycle, compare the DUT pins with what the model says should be lit.
    always @(posedge clk) begin
        logic [6:0] eSeg;
        logic [3:0] eAn;
        logic       eDp;
        int         digit;
        #1;
        eSeg = 7'h7F; eAn = 4'hF; eDp = 1'b1;
        if (mLit) begin
            digit = (mT / RD) % ND;
            eSeg = segTable[int'((mShownData >> (4 * digit)) & 16'hF)];
`ifdef SEVSEG_LZB_EN
            if (digit > 0 && (mShownData >> (4 * digit)) == 16'h0 && (mShownDp >> digit) == 4'h0)
                eSeg = 7'h7F;
`endif
            eDp = ~mShownDp[digit];
            eAn = ~(4'b0001 << digit);
        end
        checkVal("scan.seg", 32'(seg), 32'(eSeg));
        checkVal("scan.an", 32'(an), 32'(eAn));
        checkVal("scan.dp", 32'(oDp), 32'(eDp));
        checkVal("scan.tick", 32'(tick), 32'(mTick));
    end

    task automatic applyStimulus;
        #1 rst = 1'b1;
        waitEdge(3);
        checkOutput("reset", 7'h7F, 4'hF, 1'b1, 1'b0);
        @(negedge clk); rst = 1'b0; enable = 1'b1; load = 1'b1; data = 16'h1234; dp = 4'h0;
        waitEdge(1);
        checkOutput("firstSlot", 7'h40, 4'hE, 1'b1, 1'b0);
        @(negedge clk); load = 1'b0;
        waitEdge(15);
        checkOutput("wrapDigit0", 7'h19, 4'hE, 1'b1, 1'b1);
        waitEdge(1);
        checkOutput("tickOnce", 7'h19, 4'hE, 1'b1, 1'b0);
        waitEdge(3);
        checkOutput("digit1", 7'h30, 4'hD, 1'b1, 1'b0);
        @(negedge clk); load = 1'b1; data = 16'hABCD;
        waitEdge(1);
        @(negedge clk); load = 1'b0;
        waitEdge(3);
        checkOutput("noTearDigit2", 7'h24, 4'hB, 1'b1, 1'b0);
        checkVal("hex0Blank.seg", 32'(seg2), 32'h7F);
        checkVal("hex0Blank.an", 32'(an2), 32'hB);
        checkVal("hex0Blank.dp", 32'(oDp2), 32'h1);
        waitEdge(4);
        checkOutput("noTearDigit3", 7'h79, 4'h7, 1'b1, 1'b0);
        checkVal("hex0Nine.seg", 32'(seg2), 32'h10);
        checkVal("hex0Nine.tick", 32'(tick2), 32'h0);
        waitEdge(4);
        checkOutput("newFrameD", 7'h21, 4'hE, 1'b1, 1'b1);
        waitEdge(12);
        checkOutput("newFrameA", 7'h08, 4'h7, 1'b1, 1'b0);
        waitEdge(3);
        @(negedge clk); load = 1'b1; data = 16'h0F0F; dp = 4'b0010;
        waitEdge(1);
        checkOutput("bypassF", 7'h0E, 4'hE, 1'b1, 1'b1);
        @(negedge clk); load = 1'b0; dp = 4'h0;
        waitEdge(4);
        checkOutput("bypassDp", 7'h40, 4'hD, 1'b0, 1'b0);
        @(negedge clk); load = 1'b1; data = 16'h1111; dp = 4'hF;
        waitEdge(1);
        @(negedge clk); load = 1'b0;
        waitEdge(6);
        @(negedge clk); load = 1'b1; data = 16'h2468; dp = 4'h0;
        waitEdge(1);
        @(negedge clk); load = 1'b0;
        waitEdge(4);
        checkOutput("lastLoadWins", 7'h00, 4'hE, 1'b1, 1'b1);
        waitEdge(2);
        @(negedge clk); enable = 1'b0;
        waitEdge(1);
        checkOutput("disabled", 7'h7F, 4'hF, 1'b1, 1'b0);
        @(negedge clk); load = 1'b1; data = 16'h0050; dp = 4'h0;
        waitEdge(1);
        @(negedge clk); load = 1'b0;
        waitEdge(20);
        checkOutput("disabledHold", 7'h7F, 4'hF, 1'b1, 1'b0);
        @(negedge clk); enable = 1'b1;
        waitEdge(1);
        checkOutput("reEnable", 7'h00, 4'hE, 1'b1, 1'b0);
        waitEdge(15);
        checkOutput("commitAfterEn", 7'h40, 4'hE, 1'b1, 1'b1);
        waitEdge(4);
        checkOutput("fiveDigit1", 7'h12, 4'hD, 1'b1, 1'b0);
        waitEdge(4);
        checkOutput("zeroDigit2", HIGH_ZERO, 4'hB, 1'b1, 1'b0);
        waitEdge(4);
        checkOutput("zeroDigit3", HIGH_ZERO, 4'h7, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncReset", 7'h7F, 4'hF, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        waitEdge(1);
        checkOutput("afterReset", 7'h40, 4'hE, 1'b1, 1'b0);
    endtask

    initial begin
        applyStimulus();
        waitEdge(2);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
